// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR row sequencer slice.
//   - default geometry: NROWS, ROW_AW, NNZ_AW, RAM_LAT
//   - sequencer state encoding (3-bit constants, kept as plain localparams
//     so older blocks that compare raw state codes keep working)
//   - extract_ptr(): pulls the nonzero pointer out of a row-pointer word
// ---------------------------------------------------------------------------
package csr_pkg;

  localparam int CSR_NROWS   = 560;
  localparam int CSR_ROW_AW  = 10;
  localparam int CSR_NNZ_AW  = 14;
  localparam int CSR_RAM_LAT = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RD_BASE   = 3'd1;
  localparam state_t ST_WAIT_BASE = 3'd2;
  localparam state_t ST_RD_END    = 3'd3;
  localparam state_t ST_WAIT_END  = 3'd4;
  localparam state_t ST_ISSUE     = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // Row-pointer words are 32 bits wide but only the low `aw` bits address
  // the value/column RAMs; everything above is masked away.
  function automatic logic [31:0] extract_ptr(input logic [31:0] data,
                                               input int unsigned aw);
    logic [31:0] mask;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    return data & mask;
  endfunction

endpackage

// File: rtl/csr_lat_wait.sv
// ---------------------------------------------------------------------------
// csr_lat_wait
// Down-counter that marks the cycle in which row-pointer RAM read data
// becomes valid. Loading it in the cycle the address is first presented
// makes `fire` rise exactly LAT cycles later, for one cycle.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous, active-low reset
//   load  in  address presented this cycle; (re)start the count
//   fire  out read data valid this cycle
// ---------------------------------------------------------------------------
module csr_lat_wait #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic fire
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  // Counts LAT, LAT-1, ..., 1, then parks at zero until the next load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign fire = (cnt == CW'(1));

endmodule

// File: rtl/csr_row_sequencer.sv
// ---------------------------------------------------------------------------
// csr_row_sequencer
// Control front-end for the CSR sparse-matrix x dense-vector MAC datapath.
// Walks the row-pointer RAM, then issues one nonzero index per accepted
// cycle, tagged with its row and first/last-of-row flags. Rows without
// nonzeros produce a one-cycle empty_row pulse instead of any issue.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start             one-cycle pulse, begins a pass when idle
//   busy / done       pass in progress / one-cycle end-of-pass pulse
//   err               sticky: a row pointer decreased during the pass
//   row_addr/row_data row-pointer RAM read port (data RAM_LAT cycles later)
//   nz_addr/nz_valid  issued nonzero address, valid/ready handshake
//   nz_ready
//   nz_first/nz_last  issued nonzero is first/last of its row
//   nz_row            row of the current nonzero or empty-row event
//   empty_row         row nz_row has no nonzeros
// ---------------------------------------------------------------------------
module csr_row_sequencer
  import csr_pkg::*;
#(
  parameter int NROWS   = CSR_NROWS,
  parameter int ROW_AW  = CSR_ROW_AW,
  parameter int NNZ_AW  = CSR_NNZ_AW,
  parameter int RAM_LAT = CSR_RAM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROW_AW-1:0] row_addr,
  input  logic [31:0]       row_data,
  output logic [NNZ_AW-1:0] nz_addr,
  output logic              nz_valid,
  input  logic              nz_ready,
  output logic              nz_first,
  output logic              nz_last,
  output logic [ROW_AW-1:0] nz_row,
  output logic              empty_row
);

  state_t            state;
  logic [ROW_AW-1:0] r;
  logic [ROW_AW-1:0] row_addr_q;
  logic [ROW_AW-1:0] nz_row_q;
  logic [NNZ_AW-1:0] base;
  logic [NNZ_AW-1:0] end_ptr;
  logic [NNZ_AW-1:0] ptr;
  logic              empty_q;
  logic              err_q;

  logic              lat_load;
  logic              lat_fire;

  logic [31:0]       ptr_word;
  logic [NNZ_AW-1:0] ptr_in;
  logic              unused_ptr_hi;

  logic              is_last;
  logic              last_row;
  logic              end_capture;
  logic              row_empty;
  logic              advance;

  assign ptr_word      = extract_ptr(row_data, NNZ_AW);
  assign ptr_in        = ptr_word[NNZ_AW-1:0];
  assign unused_ptr_hi = ^ptr_word[31:NNZ_AW];

  // One counter serves both pointer reads: it is restarted whenever a new
  // row-pointer address is presented.
  assign lat_load = (state == ST_RD_BASE) || (state == ST_RD_END);

  csr_lat_wait #(
    .LAT (RAM_LAT)
  ) u_lat_wait (
    .clk  (clk),
    .rst  (rst),
    .load (lat_load),
    .fire (lat_fire)
  );

  assign is_last     = (ptr == end_ptr - NNZ_AW'(1));
  assign last_row    = (r == ROW_AW'(NROWS - 1));
  assign end_capture = (state == ST_WAIT_END) && lat_fire;

  // A decreasing pointer is folded into the empty-row path so the pass
  // still walks every row; it only raises err on the way.
  assign row_empty = end_capture && (ptr_in <= base);

  // Leaving a row: either it was empty, or its last nonzero was accepted.
  assign advance = row_empty ||
                   ((state == ST_ISSUE) && nz_ready && is_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      r          <= '0;
      row_addr_q <= '0;
      nz_row_q   <= '0;
      base       <= '0;
      end_ptr    <= '0;
      ptr        <= '0;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      empty_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            err_q      <= 1'b0;
            r          <= '0;
            row_addr_q <= '0;
            state      <= ST_RD_BASE;
          end
        end

        ST_RD_BASE: begin
          state <= ST_WAIT_BASE;
        end

        ST_WAIT_BASE: begin
          if (lat_fire) begin
            base       <= ptr_in;
            row_addr_q <= r + ROW_AW'(1);
            state      <= ST_RD_END;
          end
        end

        ST_RD_END: begin
          state <= ST_WAIT_END;
        end

        ST_WAIT_END: begin
          if (lat_fire) begin
            end_ptr  <= ptr_in;
            nz_row_q <= r;
            if (ptr_in <= base) begin
              empty_q <= 1'b1;
              if (ptr_in < base) begin
                err_q <= 1'b1;
              end
            end else begin
              ptr   <= base;
              state <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (nz_ready) begin
            ptr <= ptr + NNZ_AW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // The next row's base is this row's end, so only one RAM read per
      // row is needed after the first. In the empty case end_ptr has not
      // been written yet, so the freshly read pointer is used directly.
      if (advance) begin
        base <= (state == ST_ISSUE) ? end_ptr : ptr_in;
        if (last_row) begin
          state <= ST_DONE;
        end else begin
          r          <= r + ROW_AW'(1);
          row_addr_q <= r + ROW_AW'(2);
          state      <= ST_RD_END;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;
  assign row_addr  = row_addr_q;
  assign nz_valid  = (state == ST_ISSUE);
  assign nz_addr   = ptr;
  assign nz_first  = nz_valid && (ptr == base);
  assign nz_last   = nz_valid && is_last;
  assign nz_row    = nz_row_q;
  assign empty_row = empty_q;

endmodule

// File: tb/tb_csr_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csr_row_sequencer
// Directed bench for csr_row_sequencer. Two instances share one small
// row-pointer memory: u_dut1 with a 1-cycle RAM and u_dut3 with a 3-cycle
// RAM. Every cycle the bench drives nz_ready, then logs accepted nonzeros
// and empty-row events; the logs are compared to hand-built event lists.
// ---------------------------------------------------------------------------
module tb_csr_row_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1;
  logic        start3;
  logic        nz_ready;

  logic        busy1, done1, err1, nz_valid1, nz_first1, nz_last1, empty_row1;
  logic [9:0]  row_addr1, nz_row1;
  logic [13:0] nz_addr1;
  logic [31:0] row_data1;

  logic        busy3, done3, err3, nz_valid3, nz_first3, nz_last3, empty_row3;
  logic [9:0]  row_addr3, nz_row3;
  logic [13:0] nz_addr3;
  logic [31:0] row_data3;

  logic [31:0] mem [0:7];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  csr_row_sequencer #(
    .NROWS(4), .ROW_AW(10), .NNZ_AW(14), .RAM_LAT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .err(err1), .row_addr(row_addr1), .row_data(row_data1),
    .nz_addr(nz_addr1), .nz_valid(nz_valid1), .nz_ready(nz_ready),
    .nz_first(nz_first1), .nz_last(nz_last1), .nz_row(nz_row1),
    .empty_row(empty_row1)
  );

  csr_row_sequencer #(
    .NROWS(4), .ROW_AW(10), .NNZ_AW(14), .RAM_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .err(err3), .row_addr(row_addr3), .row_data(row_data3),
    .nz_addr(nz_addr3), .nz_valid(nz_valid3), .nz_ready(nz_ready),
    .nz_first(nz_first3), .nz_last(nz_last3), .nz_row(nz_row3),
    .empty_row(empty_row3)
  );

  // Row-pointer RAM models with 1 and 3 cycles of read latency.
  always @(posedge clk) pipe1 <= mem[row_addr1[2:0]];
  assign row_data1 = pipe1;

  always @(posedge clk) begin
    pipe3[0] <= mem[row_addr3[2:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign row_data3 = pipe3[2];

  int          testsRun;
  int          testsFailed;
  int          cyc;
  int          readyMode;
  logic [3:0]  readyPat;
  logic [31:0] log1[$];
  logic [31:0] log3[$];
  int          hsCyc1[$];
  int          hsCyc3[$];
  logic [31:0] expQ[$];
  int          doneCnt1, doneCnt3;
  int          busyBad;
  int          stallSeen, stallBad;
  logic        stallPrev;
  logic [25:0] stallSnap;

  function automatic logic [31:0] evCode(input logic [3:0] t,
                                         input logic [9:0] row,
                                         input logic f, input logic l,
                                         input logic [13:0] a);
    return {t, row, f, l, 2'b00, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drive nz_ready for the coming edge, then record what that edge will see.
  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    nz_ready = (readyMode == 0) ? 1'b1 : readyPat[cyc % 4];

    if (nz_valid1 && nz_ready) begin
      log1.push_back(evCode(4'd1, nz_row1, nz_first1, nz_last1, nz_addr1));
      hsCyc1.push_back(cyc);
    end
    if (empty_row1) log1.push_back(evCode(4'd2, nz_row1, 1'b0, 1'b0, 14'd0));
    if (done1) begin
      doneCnt1++;
      if (busy1) busyBad++;
    end
    if (stallPrev) begin
      stallSeen++;
      if (!nz_valid1 || {nz_addr1, nz_row1, nz_first1, nz_last1} != stallSnap)
        stallBad++;
    end
    stallPrev = nz_valid1 && !nz_ready;
    stallSnap = {nz_addr1, nz_row1, nz_first1, nz_last1};

    if (nz_valid3 && nz_ready) begin
      log3.push_back(evCode(4'd1, nz_row3, nz_first3, nz_last3, nz_addr3));
      hsCyc3.push_back(cyc);
    end
    if (empty_row3) log3.push_back(evCode(4'd2, nz_row3, 1'b0, 1'b0, 14'd0));
    if (done3) begin
      doneCnt3++;
      if (busy3) busyBad++;
    end
  endtask

  task automatic setMem(input int p0, input int p1, input int p2,
                        input int p3, input int p4);
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3; mem[4] = p4;
    mem[5] = 0;  mem[6] = 0;  mem[7] = 0;
  endtask

  // Start a pass on instance k (0: 1-cycle RAM, 1: 3-cycle RAM) and run it
  // to done within a cycle budget; optionally pulse start again mid-pass.
  task automatic applyStimulus(input int k, input int mode,
                               input int extraStarts, input string tag);
    int n;
    int seen;
    readyMode = mode;
    if (k == 0) begin
      log1.delete(); hsCyc1.delete(); doneCnt1 = 0;
      start1 = 1'b1;
    end else begin
      log3.delete(); hsCyc3.delete(); doneCnt3 = 0;
      start3 = 1'b1;
    end
    stepCycle();
    start1 = 1'b0;
    start3 = 1'b0;
    n = 0;
    seen = 0;
    while (seen == 0 && n < 300) begin
      stepCycle();
      seen = (k == 0) ? doneCnt1 : doneCnt3;
      start3 = (extraStarts != 0 && seen == 0 && (n % 7) == 3);
      n++;
    end
    start3 = 1'b0;
    checkOutput({tag, "_done_reached"}, (seen != 0), 1);
    repeat (6) stepCycle();
  endtask

  task automatic compareLog(input int k, input string tag);
    int n;
    n = (k == 0) ? log1.size() : log3.size();
    checkOutput({tag, "_event_count"}, n, expQ.size());
    for (int i = 0; i < expQ.size() && i < n; i++) begin
      checkOutput($sformatf("%s_ev%0d", tag, i),
                  (k == 0) ? log1[i] : log3[i], expQ[i]);
    end
  endtask

  task automatic loadExpectedMain();
    expQ.delete();
    expQ.push_back(evCode(4'd1, 10'd0, 1'b1, 1'b0, 14'd0));
    expQ.push_back(evCode(4'd1, 10'd0, 1'b0, 1'b1, 14'd1));
    expQ.push_back(evCode(4'd1, 10'd1, 1'b1, 1'b1, 14'd2));
    expQ.push_back(evCode(4'd2, 10'd2, 1'b0, 1'b0, 14'd0));
    expQ.push_back(evCode(4'd1, 10'd3, 1'b1, 1'b0, 14'd3));
    expQ.push_back(evCode(4'd1, 10'd3, 1'b0, 1'b0, 14'd4));
    expQ.push_back(evCode(4'd1, 10'd3, 1'b0, 1'b1, 14'd5));
  endtask

  initial begin
    int found;
    int n;
    testsRun    = 0;
    testsFailed = 0;
    cyc         = 0;
    readyMode   = 0;
    readyPat    = 4'b1001;
    doneCnt1    = 0;
    doneCnt3    = 0;
    busyBad     = 0;
    stallSeen   = 0;
    stallBad    = 0;
    stallPrev   = 1'b0;
    stallSnap   = '0;
    rst         = 1'b0;
    start1      = 1'b0;
    start3      = 1'b0;
    nz_ready    = 1'b1;
    setMem(0, 2, 3, 3, 6);

    // Reset state, with start held high to show reset wins.
    start1 = 1'b1;
    repeat (3) stepCycle();
    start1 = 1'b0;
    checkOutput("rst_ctrl1", {busy1, done1, err1, nz_valid1, nz_first1,
                              nz_last1, empty_row1}, 0);
    checkOutput("rst_row_addr1", row_addr1, 0);
    checkOutput("rst_nz_addr1", nz_addr1, 0);
    checkOutput("rst_nz_row1", nz_row1, 0);
    checkOutput("rst_ctrl3", {busy3, done3, err3, nz_valid3, row_addr3,
                              nz_addr3}, 0);
    rst = 1'b1;
    stepCycle();

    // Main matrix, always ready.
    setMem(0, 2, 3, 3, 6);
    busyBad = 0;
    applyStimulus(0, 0, 0, "t1");
    loadExpectedMain();
    compareLog(0, "t1");
    checkOutput("t1_done_count", doneCnt1, 1);
    checkOutput("t1_err", err1, 0);
    checkOutput("t1_busy_low_at_done", busyBad, 0);
    if (hsCyc1.size() >= 3)
      checkOutput("t1_row_gap", hsCyc1[2] - hsCyc1[1] - 1, 2);

    // Same matrix with nz_ready toggling 1,0,0,1.
    stallSeen = 0;
    stallBad  = 0;
    applyStimulus(0, 1, 0, "t2");
    compareLog(0, "t2");
    checkOutput("t2_done_count", doneCnt1, 1);
    checkOutput("t2_stalls_seen", (stallSeen > 0), 1);
    checkOutput("t2_stall_stable", stallBad, 0);
    readyMode = 0;

    // All rows empty.
    setMem(7, 7, 7, 7, 7);
    applyStimulus(0, 0, 0, "t3");
    expQ.delete();
    for (int i = 0; i < 4; i++)
      expQ.push_back(evCode(4'd2, 10'(i), 1'b0, 1'b0, 14'd0));
    compareLog(0, "t3");
    checkOutput("t3_done_count", doneCnt1, 1);
    checkOutput("t3_err", err1, 0);

    // Decreasing pointer: row 1 goes 5 -> 3.
    setMem(0, 5, 3, 4, 4);
    applyStimulus(0, 0, 0, "t4");
    expQ.delete();
    expQ.push_back(evCode(4'd1, 10'd0, 1'b1, 1'b0, 14'd0));
    expQ.push_back(evCode(4'd1, 10'd0, 1'b0, 1'b0, 14'd1));
    expQ.push_back(evCode(4'd1, 10'd0, 1'b0, 1'b0, 14'd2));
    expQ.push_back(evCode(4'd1, 10'd0, 1'b0, 1'b0, 14'd3));
    expQ.push_back(evCode(4'd1, 10'd0, 1'b0, 1'b1, 14'd4));
    expQ.push_back(evCode(4'd2, 10'd1, 1'b0, 1'b0, 14'd0));
    expQ.push_back(evCode(4'd1, 10'd2, 1'b1, 1'b1, 14'd3));
    expQ.push_back(evCode(4'd2, 10'd3, 1'b0, 1'b0, 14'd0));
    compareLog(0, "t4");
    checkOutput("t4_done_count", doneCnt1, 1);
    checkOutput("t4_err_set", err1, 1);
    repeat (5) stepCycle();
    checkOutput("t4_err_sticky", err1, 1);
    setMem(0, 2, 3, 3, 6);
    applyStimulus(0, 0, 0, "t4b");
    loadExpectedMain();
    compareLog(0, "t4b");
    checkOutput("t4b_err_cleared", err1, 0);

    // Reset while issuing nz_addr 1, then replay.
    readyMode = 0;
    doneCnt1  = 0;
    start1    = 1'b1;
    stepCycle();
    start1 = 1'b0;
    found  = 0;
    n      = 0;
    while (found == 0 && n < 50) begin
      stepCycle();
      if (nz_valid1 && nz_addr1 == 14'd1) found = 1;
      n++;
    end
    checkOutput("t5_reached_addr1", found, 1);
    rst = 1'b0;
    stepCycle();
    checkOutput("t5_ctrl_zero", {busy1, done1, err1, nz_valid1, nz_first1,
                                 nz_last1, empty_row1}, 0);
    checkOutput("t5_row_addr_zero", row_addr1, 0);
    checkOutput("t5_nz_addr_zero", nz_addr1, 0);
    checkOutput("t5_nz_row_zero", nz_row1, 0);
    rst = 1'b1;
    stepCycle();
    checkOutput("t5_no_done", doneCnt1, 0);
    applyStimulus(0, 0, 0, "t5");
    compareLog(0, "t5");
    checkOutput("t5_done_count", doneCnt1, 1);

    // Three-cycle RAM with start pulsed during the pass.
    busyBad = 0;
    applyStimulus(1, 0, 1, "t6");
    loadExpectedMain();
    compareLog(1, "t6");
    checkOutput("t6_done_count", doneCnt3, 1);
    checkOutput("t6_err", err3, 0);
    checkOutput("t6_busy_low_at_done", busyBad, 0);
    if (hsCyc3.size() >= 5) begin
      checkOutput("t6_row_gap_a", hsCyc3[2] - hsCyc3[1] - 1, 4);
      checkOutput("t6_issue_back_to_back", hsCyc3[4] - hsCyc3[3], 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
